// File: rtl/i2c_bitxmit_ms.sv
`timescale 1ns/1ps
// i2c_bitxmit_ms: executes one I2C bus symbol per command with bit-rate
// selection, clock stretching/timeout, read capture and arbitration loss.
module i2c_bitxmit_ms #(
  parameter int CNTW        = 12,
  parameter bit STRETCH_EN  = 1'b1,
  parameter int STRETCH_MAX = 4095
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CNTW-1:0] phase_len,
  input  logic [2:0]      command,
  output logic            ready,
  output logic            rdata,
  output logic            arblost,
  output logic            timeout,
  inout  wire             sck,
  inout  wire             sda
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_WAIT   = 3'd1;
  localparam logic [2:0] C_BIT0   = 3'd2;
  localparam logic [2:0] C_BIT1   = 3'd3;
  localparam logic [2:0] C_START  = 3'd4;
  localparam logic [2:0] C_STOP   = 3'd5;
  localparam logic [2:0] C_RBIT   = 3'd6;
  localparam logic [2:0] C_RSTART = 3'd7;

  localparam logic [CNTW-1:0] TWO   = CNTW'(2);
  localparam logic [CNTW-1:0] SMAX1 = CNTW'(STRETCH_MAX - 1);

  typedef enum logic [2:0] {
    ST_S0, ST_PRE, ST_BIT, ST_POST, ST_END
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] str_q, str_d;
  logic [CNTW-1:0] len_q, len_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            sck_oe_q, sck_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            rdata_q, rdata_d;
  logic            arb_q, arb_d;
  logic            to_q, to_d;
  logic            sck_m_q, sck_s_q;
  logic            sda_m_q, sda_s_q;

  logic [CNTW-1:0] plen_c;
  logic            last_c;
  logic            stretchy_c;
  logic            hold_c;

  // Returns {sck_low, sda_low} for a command in a given phase.
  function automatic logic [1:0] lvl(
    input logic [2:0] c,
    input state_e     s,
    input logic       arb
  );
    logic pre, bt, pst, sk, sd;
    pre = (s == ST_PRE);
    bt  = (s == ST_BIT);
    pst = (s == ST_POST);
    sk  = 1'b0;
    sd  = 1'b0;
    case (c)
      C_BIT0: begin
        sk = pre | pst;
        sd = ~arb;
      end
      C_BIT1, C_RBIT: sk = pre | pst;
      C_START: sd = (bt | pst) & ~arb;
      C_STOP:  sd = pre & ~arb;
      C_RSTART: begin
        sk = pre;
        sd = pst & ~arb;
      end
      default: ;
    endcase
    return {sk, sd};
  endfunction

  assign plen_c = (phase_len < TWO) ? TWO : phase_len;
  assign last_c = (cnt_q == len_q - CNTW'(1));
  assign stretchy_c = (cmd_q == C_BIT0) || (cmd_q == C_BIT1) ||
                      (cmd_q == C_RBIT) || (cmd_q == C_RSTART);
  assign hold_c = STRETCH_EN && stretchy_c &&
                  (cnt_q >= TWO) && !sck_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_S0;
      cnt_q    <= '0;
      str_q    <= '0;
      len_q    <= TWO;
      cmd_q    <= C_IDLE;
      sck_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rdata_q  <= 1'b1;
      arb_q    <= 1'b0;
      to_q     <= 1'b0;
      sck_m_q  <= 1'b1;
      sck_s_q  <= 1'b1;
      sda_m_q  <= 1'b1;
      sda_s_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      str_q    <= str_d;
      len_q    <= len_d;
      cmd_q    <= cmd_d;
      sck_oe_q <= sck_oe_d;
      sda_oe_q <= sda_oe_d;
      rdata_q  <= rdata_d;
      arb_q    <= arb_d;
      to_q     <= to_d;
      sck_m_q  <= sck;
      sck_s_q  <= sck_m_q;
      sda_m_q  <= sda;
      sda_s_q  <= sda_m_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    str_d    = str_q;
    len_d    = len_q;
    cmd_d    = cmd_q;
    sck_oe_d = sck_oe_q;
    sda_oe_d = sda_oe_q;
    rdata_d  = rdata_q;
    arb_d    = arb_q;
    to_d     = to_q;
    unique case (state_q)
      ST_S0: begin
        if (command != C_WAIT) begin
          state_d = ST_PRE;
          cmd_d   = command;
          len_d   = plen_c;
          cnt_d   = '0;
          to_d    = 1'b0;
          if (command == C_IDLE) arb_d = 1'b0;
          {sck_oe_d, sda_oe_d} = lvl(command, ST_PRE, arb_d);
        end
      end
      ST_PRE: begin
        if (last_c) begin
          state_d = ST_BIT;
          cnt_d   = '0;
          str_d   = '0;
          if (cmd_q == C_START && !sda_s_q) arb_d = 1'b1;
          {sck_oe_d, sda_oe_d} = lvl(cmd_q, ST_BIT, arb_d);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_BIT: begin
        if (hold_c) begin
          // Slave holds SCK low: stall the phase, give up at the limit.
          if (str_q == SMAX1) begin
            to_d     = 1'b1;
            state_d  = ST_END;
            sck_oe_d = 1'b0;
            sda_oe_d = 1'b0;
          end else begin
            str_d = str_q + CNTW'(1);
          end
        end else if (last_c) begin
          state_d = ST_POST;
          cnt_d   = '0;
          rdata_d = sda_s_q;
          if (cmd_q == C_BIT1 && !sda_s_q) arb_d = 1'b1;
          {sck_oe_d, sda_oe_d} = lvl(cmd_q, ST_POST, arb_d);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_POST: begin
        if (last_c) begin
          state_d = ST_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_END: begin
        if (command == C_WAIT) state_d = ST_S0;
      end
      default: state_d = ST_S0;
    endcase
  end

  always_comb begin
    ready   = (state_q == ST_END);
    rdata   = rdata_q;
    arblost = arb_q;
    timeout = to_q;
  end

  assign sck = sck_oe_q ? 1'b0 : 1'bz;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_bitxmit_ms.sv
`timescale 1ns/1ps
// tb_i2c_bitxmit_ms: directed and randomized symbol checks against a
// phase-table model of the I2C bit transmitter.
module tb_i2c_bitxmit_ms;

  localparam int CNTW = 12;
  localparam int SMAX = 20;

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_WAIT   = 3'd1;
  localparam logic [2:0] C_BIT0   = 3'd2;
  localparam logic [2:0] C_BIT1   = 3'd3;
  localparam logic [2:0] C_START  = 3'd4;
  localparam logic [2:0] C_STOP   = 3'd5;
  localparam logic [2:0] C_RBIT   = 3'd6;
  localparam logic [2:0] C_RSTART = 3'd7;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CNTW-1:0] phase_len = CNTW'(4);
  logic [2:0]      command = C_WAIT;
  logic            ready, rdata, arblost, timeout;
  wire             sck, sda;
  logic            tb_sck_pull = 1'b0;
  logic            tb_sda_pull = 1'b0;

  int   total = 0;
  int   bad = 0;
  logic tr_sck [0:255];
  logic tr_sda [0:255];

  pullup (sck);
  pullup (sda);
  assign sck = tb_sck_pull ? 1'b0 : 1'bz;
  assign sda = tb_sda_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_bitxmit_ms #(
    .CNTW(CNTW),
    .STRETCH_EN(1'b1),
    .STRETCH_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .phase_len(phase_len),
    .command(command),
    .ready(ready),
    .rdata(rdata),
    .arblost(arblost),
    .timeout(timeout),
    .sck(sck),
    .sda(sda)
  );

  // Pin level (1 = released) for command c in phase ph (0 PRE,1 BIT,2 POST).
  function automatic logic exp_pin(logic [2:0] c, int ph, logic arb,
                                   logic is_sda);
    logic [5:0] v;
    logic [2:0] s;
    case (c)
      C_BIT0:         v = 6'b010_000;
      C_BIT1, C_RBIT: v = 6'b010_111;
      C_START:        v = 6'b111_100;
      C_STOP:         v = 6'b111_011;
      C_RSTART:       v = 6'b011_110;
      default:        v = 6'b111_111;
    endcase
    if (is_sda && arb && c != C_RBIT && c != C_IDLE) v[2:0] = 3'b111;
    s = is_sda ? v[2:0] : v[5:3];
    return s[2-ph];
  endfunction

  function automatic logic sda_at(int k, logic [2:0] c, int L, logic a0,
                                  logic a1, logic ps, logic p);
    int ph;
    if (p) return 1'b0;
    if (k < 0) return ps;
    ph = k / L;
    return exp_pin(c, ph, (ph == 0) ? a0 : a1, 1'b1);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    command = C_WAIT;
    phase_len = CNTW'(4);
    tb_sck_pull = 1'b0;
    tb_sda_pull = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Runs one symbol; trace index k = cycles after the accepting edge.
  task automatic do_sym(input logic [2:0] c, input int len, input logic p,
                        input int hs, input int hl, output int n,
                        output logic ra);
    bit got;
    int k;
    tb_sda_pull = p;
    repeat (3) @(negedge clk);
    phase_len = CNTW'(len);
    command = c;
    @(posedge clk);
    got = 0;
    k = 0;
    n = -1;
    while (!got && k < 200) begin
      #1;
      tb_sck_pull = (k >= hs) && (k < hs + hl);
      #1;
      tr_sck[k] = sck;
      tr_sda[k] = sda;
      if (ready) begin
        got = 1;
        n = k;
      end else begin
        @(posedge clk);
        k++;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL sym_ready: cmd=%0d ready not seen in 200 cycles", c);
    end
    @(negedge clk);
    command = C_WAIT;
    tb_sda_pull = 1'b0;
    tb_sck_pull = 1'b0;
    @(posedge clk);
    #1;
    ra = ready;
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (sck !== 1'b1) begin bad++; $display("FAIL rst_sck: got %b want 1", sck); end
    if (sda !== 1'b1) begin bad++; $display("FAIL rst_sda: got %b want 1", sda); end
    if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    if (rdata !== 1'b1) begin bad++; $display("FAIL rst_rdata: got %b want 1", rdata); end
    if (arblost !== 1'b0) begin bad++; $display("FAIL rst_arb: got %b want 0", arblost); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL rst_to: got %b want 0", timeout); end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL wait_idle: ready %b want 0", ready); end
  endtask

  task automatic test_start();
    int n;
    logic ra;
    bit ok;
    do_sym(C_START, 4, 1'b0, -1, 0, n, ra);
    total++;
    if (n !== 12) begin bad++; $display("FAIL start_len: got %0d want 12", n); end
    ok = 1;
    for (int k = 0; k < 12; k++) begin
      if (tr_sda[k] !== (k < 4)) ok = 0;
      if (tr_sck[k] !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL start_lines: trace differs from z/0/0 sda, z sck"); end
    total++;
    if (ra !== 1'b0) begin bad++; $display("FAIL start_s0: ready %b want 0 after WAIT", ra); end
  endtask

  task automatic test_bits();
    int n;
    logic ra;
    bit ok;
    for (int b = 0; b < 2; b++) begin
      do_sym((b == 0) ? C_BIT0 : C_BIT1, 4, 1'b0, -1, 0, n, ra);
      total++;
      if (n !== 12) begin bad++; $display("FAIL bit%0d_len: got %0d want 12", b, n); end
      ok = 1;
      for (int k = 0; k < 12; k++) begin
        if (tr_sck[k] !== (k >= 4 && k < 8)) ok = 0;
        if (tr_sda[k] !== logic'(b)) ok = 0;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL bit%0d_lines: trace differs from model", b); end
    end
  endtask

  task automatic test_rbit();
    int n;
    logic ra;
    do_sym(C_RBIT, 4, 1'b1, -1, 0, n, ra);
    total += 2;
    if (rdata !== 1'b0) begin bad++; $display("FAIL rbit0: rdata %b want 0", rdata); end
    if (arblost !== 1'b0) begin bad++; $display("FAIL rbit_arb: arblost %b want 0", arblost); end
    do_sym(C_RBIT, 5, 1'b0, -1, 0, n, ra);
    total++;
    if (rdata !== 1'b1) begin bad++; $display("FAIL rbit1: rdata %b want 1", rdata); end
  endtask

  task automatic test_arb();
    int n;
    logic ra;
    bit ok;
    do_sym(C_BIT1, 4, 1'b1, -1, 0, n, ra);
    total++;
    if (arblost !== 1'b1) begin bad++; $display("FAIL arb_set: arblost %b want 1", arblost); end
    do_sym(C_BIT0, 4, 1'b0, -1, 0, n, ra);
    ok = 1;
    for (int k = 0; k < 12; k++) begin
      if (tr_sda[k] !== 1'b1) ok = 0;
      if (tr_sck[k] !== (k >= 4 && k < 8)) ok = 0;
    end
    total += 2;
    if (!ok) begin bad++; $display("FAIL arb_bit0: sda not released after loss"); end
    if (arblost !== 1'b1) begin bad++; $display("FAIL arb_sticky: arblost %b want 1", arblost); end
    do_sym(C_IDLE, 3, 1'b0, -1, 0, n, ra);
    total++;
    if (arblost !== 1'b0) begin bad++; $display("FAIL arb_clr: arblost %b want 0", arblost); end
  endtask

  task automatic test_stretch();
    int n;
    logic ra;
    do_sym(C_BIT0, 4, 1'b0, 4, 10, n, ra);
    total += 2;
    if (n !== 22) begin bad++; $display("FAIL stretch_len: got %0d want 22", n); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL stretch_to: timeout %b want 0", timeout); end
  endtask

  task automatic test_timeout();
    int n;
    logic ra, rd0;
    rd0 = rdata;
    do_sym(C_BIT0, 4, 1'b0, 4, 1000, n, ra);
    total += 4;
    if (n !== 4 + 2 + SMAX) begin bad++; $display("FAIL to_len: got %0d want %0d", n, 6 + SMAX); end
    if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag: timeout %b want 1", timeout); end
    if (tr_sda[n] !== 1'b1) begin bad++; $display("FAIL to_sda: sda %b want 1", tr_sda[n]); end
    if (rdata !== rd0) begin bad++; $display("FAIL to_rdata: rdata %b want %b", rdata, rd0); end
    do_sym(C_BIT1, 4, 1'b0, -1, 0, n, ra);
    total += 2;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_clr: timeout %b want 0", timeout); end
    if (n !== 12) begin bad++; $display("FAIL to_next: got %0d want 12", n); end
  endtask

  task automatic test_async_reset();
    int n;
    logic ra;
    bit ok;
    do_sym(C_BIT1, 4, 1'b1, -1, 0, n, ra);
    total++;
    if (arblost !== 1'b1) begin bad++; $display("FAIL ar_pre: arblost %b want 1", arblost); end
    @(negedge clk);
    phase_len = CNTW'(4);
    command = C_BIT0;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total += 5;
    if (ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b want 0", ready); end
    if (arblost !== 1'b0) begin bad++; $display("FAIL ar_arb: got %b want 0", arblost); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL ar_to: got %b want 0", timeout); end
    if (rdata !== 1'b1) begin bad++; $display("FAIL ar_rdata: got %b want 1", rdata); end
    if (sck !== 1'b1) begin bad++; $display("FAIL ar_sck: got %b want 1", sck); end
    @(negedge clk);
    command = C_WAIT;
    reset = 1'b1;
    @(negedge clk);
    command = C_BIT0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (sck !== 1'b0 || sda !== 1'b0) begin
      bad++;
      $display("FAIL ar_pre_lines: sck=%b sda=%b want 0 0", sck, sda);
    end
    reset = 1'b0;
    #1;
    total++;
    if (sck !== 1'b1 || sda !== 1'b1) begin
      bad++;
      $display("FAIL ar_lines: sck=%b sda=%b want 1 1", sck, sda);
    end
    @(negedge clk);
    command = C_WAIT;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ar_s0: ready %b want 0", ready); end
    do_sym(C_BIT0, 4, 1'b0, -1, 0, n, ra);
    ok = (n == 12);
    for (int k = 0; k < 12; k++) if (tr_sda[k] !== 1'b0) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL ar_resume: len %0d want 12 with sda low", n); end
  endtask

  task automatic test_random();
    int n, L, lraw, kf;
    logic ra, p, a0, a1, arb, ps, rd, es, ed;
    logic [2:0] c;
    bit ok;
    do_reset();
    arb = 1'b0;
    ps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == C_WAIT) c = C_BIT1;
      lraw = $urandom_range(0, 6);
      L = (lraw < 2) ? 2 : lraw;
      p = ($urandom_range(0, 3) == 0);
      if (c == C_IDLE) arb = 1'b0;
      a0 = arb;
      a1 = a0 | ((c == C_START) && !sda_at(L - 3, c, L, a0, a0, ps, p));
      rd = sda_at(2 * L - 3, c, L, a0, a1, ps, p);
      do_sym(c, lraw, p, -1, 0, n, ra);
      ok = 1;
      kf = -1;
      for (int k = 0; k < 3 * L; k++) begin
        es = exp_pin(c, k / L, 1'b0, 1'b0);
        ed = sda_at(k, c, L, a0, a1, ps, p);
        if ((tr_sck[k] !== es || tr_sda[k] !== ed) && ok) begin
          ok = 0;
          kf = k;
        end
      end
      if (c == C_BIT1 && !rd) a1 = 1'b1;
      total += 6;
      if (n !== 3 * L) begin bad++; $display("FAIL rnd%0d_len: cmd=%0d got %0d want %0d", i, c, n, 3 * L); end
      if (!ok) begin
        bad++;
        $display("FAIL rnd%0d_lines: cmd=%0d L=%0d k=%0d sck=%b sda=%b want %b %b",
                 i, c, L, kf, tr_sck[kf], tr_sda[kf],
                 exp_pin(c, kf / L, 1'b0, 1'b0), sda_at(kf, c, L, a0, a1, ps, p));
      end
      if (rdata !== rd) begin bad++; $display("FAIL rnd%0d_rdata: cmd=%0d got %b want %b", i, c, rdata, rd); end
      if (arblost !== a1) begin bad++; $display("FAIL rnd%0d_arb: cmd=%0d got %b want %b", i, c, arblost, a1); end
      if (timeout !== 1'b0) begin bad++; $display("FAIL rnd%0d_to: got %b want 0", i, timeout); end
      if (ra !== 1'b0) begin bad++; $display("FAIL rnd%0d_s0: ready %b want 0", i, ra); end
      arb = a1;
      ps = exp_pin(c, 2, a1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bits();
    test_rbit();
    test_arb();
    test_stretch();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bitxmit_ms.md
Name: i2c_bitxmit_ms

Overview:
- Parametrised successor to the single-bit I2C transmitter.
- Executes one bus-level symbol per command: START, repeated START, STOP, write bit, read bit or idle.
- Adds runtime bit-rate selection, open-drain SCK with slave clock stretching and a stretch timeout, read-bit capture, and multi-master arbitration-loss detection.
- Sits below the byte/transaction sequencer and drives the I2C pins directly.

Parameters:
- CNTW, 12, width of the phase-length input and phase counter.
- STRETCH_EN, 1, 1 = honour slave clock stretching; 0 = ignore SCK readback.
- STRETCH_MAX, 4095, maximum held cycles in BIT phase before timeout (must fit CNTW).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- phase_len  input  CNTW  cycles per phase; sampled at command accept; values <2 treated as 2.
- command  input  3  0=IDLE 1=WAIT 2=BIT0 3=BIT1 4=START 5=STOP 6=RBIT 7=RSTART.
- ready  output  1  high while in END (symbol complete).
- rdata  output  1  SDA level sampled at the end of the BIT phase of the last symbol.
- arblost  output  1  sticky arbitration-loss flag.
- timeout  output  1  sticky stretch-timeout flag.
- sck  inout  1  open-drain clock (drive 0 or z).
- sda  inout  1  open-drain data (drive 0 or z).

Behaviour:
- Reset (async assert, sync-release usage): state S0, counters 0, sck z, sda z, ready 0, rdata 1, arblost 0, timeout 0.
- Pin inputs: sck and sda are each read through 2-flop synchronisers (sck_s, sda_s), also reset to 1.
- State flow: S0 -> PRE -> BIT -> POST -> END.
  - S0: when command != WAIT, latch command and phase_len (clamped to >=2), go to PRE.
  - PRE, BIT, POST: each lasts phase_len cycles. The counter runs 0..phase_len-1, then advances to the next state.
  - POST: after its last cycle, go to END.
  - END: ready=1. Return to S0 when command == WAIT.
- Handshake: the master holds command until ready, then presents WAIT. Command changes during PRE/BIT/POST are ignored (latched copy used).
- Unstretched bit period: 3*phase_len cycles. ready rises on the cycle after the last POST cycle.
- Line levels are registered and change on the edge that enters the phase. Each entry below gives PRE/BIT/POST, with z = released:
  - BIT0: sck 0/z/0; sda 0/0/0.
  - BIT1: sck 0/z/0; sda z/z/z.
  - RBIT: sck 0/z/0; sda z/z/z.
  - START: sck z/z/z; sda z/0/0.
  - STOP: sck z/z/z; sda 0/z/z.
  - RSTART: sck 0/z/z; sda z/z/0.
  - IDLE: both z in all phases.
- In END and S0 the line levels hold their last values.
- rdata: captured from sda_s on the last cycle of BIT, for every command.
- Arbitration:
  - For BIT1, and for START's PRE phase, if sda_s == 0 on the last cycle of BIT (BIT1) or the last cycle of PRE (START), set arblost.
  - Once arblost=1, all subsequent BIT0/BIT1 release sda (behave as RBIT), and START/RSTART/STOP release sda.
  - arblost is cleared only when an IDLE command is accepted.
- Clock stretching (STRETCH_EN=1; commands that pull sck low in PRE):
  - The BIT counter advances unconditionally for its first 2 cycles (synchroniser latency).
  - Thereafter the BIT counter holds while sck_s == 0, and a stretch counter increments.
  - If the stretch counter reaches STRETCH_MAX: set timeout, release sck and sda next cycle, go directly to END. rdata and arbitration are not updated.
  - The stretch counter clears on entry to BIT.
  - When STRETCH_EN=0 the counter never holds.
- timeout is sticky; it is cleared on the next accepted command.
- Counter width: CNTW-bit unsigned; no wrap is reachable since the counter terminates at phase_len-1.
- Reset mid-symbol: both lines released asynchronously; no partial symbol resumes.

Test Plan:
- phase_len=4, START, then WAIT after ready -> sda z at cycle 1, falls at cycle 5 (BIT entry), sck z throughout; ready at cycle 13; S0 one cycle after WAIT.
- phase_len=4, BIT0 then BIT1 with pull-up model -> sck low 4 / high 4 / low 4 cycles each; sda 0 for BIT0, z for BIT1; 12-cycle period each.
- RBIT with bench driving sda=0 through BIT -> rdata=0 after ready; repeat with sda=1 -> rdata=1.
- BIT1 with bench pulling sda low in BIT -> arblost=1. A following BIT0 leaves sda released. IDLE clears arblost.
- phase_len=4, STRETCH_MAX=20: bench holds sck low 10 cycles into BIT -> BIT lasts 4+~10 cycles, ready later accordingly, timeout=0. Holding sck low forever -> timeout=1, lines released, ready asserted.
- Async reset asserted mid-BIT of BIT0 -> sck, sda z immediately; ready, arblost, timeout 0; state S0.
